// File: rtl/operand_entry.sv
// Operand-capture front end: debounces ENTER/CLEAR and latches switch values
// into operand registers A and B for the downstream selector and ALU stage.

module operand_entry_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          stable_dly_q;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_TERM) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
        pulse_d = stable_q & ~stable_dly_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            pulse_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            pulse_q      <= pulse_d;
            cnt_q        <= cnt_d;
        end
    end

    assign press_o = pulse_q;
endmodule

// state    | meaning
// S_A      | waiting for operand A (sel=1)
// S_B      | A loaded, waiting for operand B (sel=0)
// S_READY  | both operands loaded; next ENTER reloads A
module operand_entry #(
    parameter int unsigned SIZE            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] sw,
    input  logic            btn_enter,
    input  logic            btn_clear,
    output logic [SIZE-1:0] a,
    output logic [SIZE-1:0] b,
    output logic            sel,
    output logic            ready,
    output logic [1:0]      state
);
    typedef enum logic [1:0] {
        S_A     = 2'b00,
        S_B     = 2'b01,
        S_READY = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] a_q, a_d;
    logic [SIZE-1:0] b_q, b_d;
    logic            enter_pulse, clear_pulse;

    operand_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_enter),
        .press_o (enter_pulse)
    );

    operand_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_clear),
        .press_o (clear_pulse)
    );

    // CLEAR takes priority over a coincident ENTER; sw is then ignored.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        if (clear_pulse) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
        end else if (enter_pulse) begin
            case (state_q)
                S_A: begin
                    a_d     = sw;
                    state_d = S_B;
                end
                S_B: begin
                    b_d     = sw;
                    state_d = S_READY;
                end
                S_READY: begin
                    a_d     = sw;
                    state_d = S_B;
                end
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign state = state_q;
    assign sel   = (state_q != S_B);
    assign ready = (state_q == S_READY);
endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry: presses push expected operand/state
// updates with their load cycle; a negedge monitor checks every output change.

module tb_operand_entry;
    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic       btn_enter;
    logic       btn_clear;
    logic [3:0] a;
    logic [3:0] b;
    logic       sel;
    logic       ready;
    logic [1:0] state;

    operand_entry #(.SIZE(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .ready     (ready),
        .state     (state)
    );

    typedef struct {
        logic [3:0] ea;
        logic [3:0] eb;
        logic [1:0] es;
        int         ecyc;
    } exp_t;

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic       mon_en = 1'b0;
    logic [9:0] prev_out = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: any change of {a,b,state} is a DUT response to be matched.
    always @(negedge clk) begin
        logic [9:0] cur;
        exp_t       e;
        cur = {a, b, state};
        if (mon_en && cur != prev_out) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_load: got a=%0h b=%0h state=%0d with nothing expected (cycle %0d)",
                         a, b, state, cyc);
            end else begin
                e = sb_q.pop_front();
                chk("a", int'(a), int'(e.ea));
                chk("b", int'(b), int'(e.eb));
                chk("state", int'(state), int'(e.es));
                chk("load_cycle", cyc, e.ecyc);
                chk("sel", int'(sel), int'(e.es != 2'b01));
                chk("ready", int'(ready), int'(e.es == 2'b10));
            end
        end
        prev_out = cur;
    end

    // Raises the chosen buttons for 'hold' cycles; a load is expected on the
    // 8th rising edge after the press first meets setup.
    task automatic press(input logic en, input logic cl, input int hold,
                         input logic expect_load, input logic [3:0] ea,
                         input logic [3:0] eb, input logic [1:0] es);
        exp_t e;
        @(negedge clk);
        if (expect_load) begin
            e.ea   = ea;
            e.eb   = eb;
            e.es   = es;
            e.ecyc = cyc + 8;
            sb_q.push_back(e);
        end
        btn_enter = en;
        btn_clear = cl;
        repeat (hold) @(negedge clk);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    task automatic pulse_enter(input int hi);
        btn_enter = 1'b1;
        repeat (hi) @(negedge clk);
        btn_enter = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        sw        = 4'h0;
        btn_enter = 1'b0;
        btn_clear = 1'b0;

        // Reset with buttons toggling
        repeat (2) begin
            @(negedge clk);
            btn_enter = ~btn_enter;
            btn_clear = ~btn_clear;
        end
        @(negedge clk);
        rst       = 1'b0;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        @(negedge clk);
        chk("rst_a", int'(a), 0);
        chk("rst_b", int'(b), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_sel", int'(sel), 1);
        chk("rst_ready", int'(ready), 0);
        mon_en = 1'b1;
        repeat (12) @(negedge clk);

        // Normal entry: long hold gives one load only
        sw = 4'hA;
        press(1'b1, 1'b0, 20, 1'b1, 4'hA, 4'h0, 2'b01);
        sw = 4'h3;
        press(1'b1, 1'b0, 10, 1'b1, 4'hA, 4'h3, 2'b10);

        // Bounce in S_READY: 3 high, 2 low, 2 high -> nothing
        sw = 4'h7;
        @(negedge clk);
        pulse_enter(3);
        repeat (2) @(negedge clk);
        pulse_enter(2);
        repeat (14) @(negedge clk);
        chk("bounce_state", int'(state), 2);
        chk("bounce_a", int'(a), 'hA);

        // Clean hold from S_READY reloads A, keeps B
        sw = 4'h5;
        press(1'b1, 1'b0, 10, 1'b1, 4'h5, 4'h3, 2'b01);

        // Simultaneous ENTER and CLEAR in S_B: clear wins
        sw = 4'h9;
        press(1'b1, 1'b1, 10, 1'b1, 4'h0, 4'h0, 2'b00);

        // Minimum accepted press: exactly DEBOUNCE_CYCLES high
        sw = 4'hB;
        press(1'b1, 1'b0, 4, 1'b1, 4'hB, 4'h0, 2'b01);

        // Reset mid-debounce: no load afterwards
        sw = 4'hE;
        @(negedge clk);
        btn_enter = 1'b1;
        repeat (4) @(negedge clk);
        mon_en    = 1'b0;
        rst       = 1'b1;
        btn_enter = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        chk("mid_rst_a", int'(a), 0);
        chk("mid_rst_state", int'(state), 0);
        repeat (14) @(negedge clk);

        // Full press after that loads normally, then CLEAR alone
        sw = 4'hC;
        press(1'b1, 1'b0, 10, 1'b1, 4'hC, 4'h0, 2'b01);
        sw = 4'h6;
        press(1'b1, 1'b0, 10, 1'b1, 4'hC, 4'h6, 2'b10);
        press(1'b0, 1'b1, 10, 1'b1, 4'h0, 4'h0, 2'b00);

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
        while (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing_load: expected a=%0h b=%0h state=%0d at cycle %0d never seen",
                     e.ea, e.eb, e.es, e.ecyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
